// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with single-cycle flush; head is readable combinationally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  // Pointer width kept at least 1 so a single-entry queue still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Explicit wrap so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Storage write; stale entries are harmless because pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at the clock edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for fetch_fifo: the owner must never overflow or underflow it.
module fetch_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic flush,
  input logic full,
  input logic empty
);

  // A push into a full queue is only legal when the head leaves in the same cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

  // Popping an empty queue means a consumer ran ahead of the data.
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(pop && empty && !flush));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential PC requests, in-order responses,
// prefetch queue toward decode, redirect with discard of in-flight responses.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h4000_0000,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] NOP_INST        = fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]   r_req_pc;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     r_kill;

  logic              w_accept;
  logic              w_deliver;
  logic              w_pop;
  logic [OW-1:0]     w_outstanding_next;
  logic [CW-1:0]     w_q_count;
  logic              w_q_full;
  logic              w_q_empty;
  logic [2*XLEN-1:0] w_q_rdata;
  logic [XLEN-1:0]   w_tag_pc;
  logic [TW-1:0]     w_tag_count;
  logic              w_tag_full;
  logic              w_tag_empty;
  logic              w_unused;

  // Credits cover both in-flight requests and buffered entries, so every
  // response that is not killed is guaranteed a queue slot.
  assign imem_req_valid = !reset && !redirect_valid
                        && (r_outstanding < OW'(MAX_OUTSTANDING))
                        && ((int'(r_outstanding) + int'(w_q_count)) < FIFO_DEPTH);
  assign imem_req_addr  = r_req_pc;

  assign w_accept  = imem_req_valid && imem_req_ready;
  assign w_deliver = imem_resp_valid && (r_kill == '0) && !redirect_valid;
  assign w_pop     = !w_q_empty && id_ready;
  assign w_outstanding_next = r_outstanding + OW'(w_accept) - OW'(imem_resp_valid);

  // Head of the queue goes straight to decode; idle slots show a NOP at PC 0.
  assign id_valid = !w_q_empty;
  assign id_pc    = w_q_empty ? '0       : w_q_rdata[2*XLEN-1:XLEN];
  assign id_inst  = w_q_empty ? NOP_INST : w_q_rdata[XLEN-1:0];

  assign w_unused = ^{w_q_full, w_tag_count, w_tag_full, w_tag_empty};

  // Fetch PC, in-flight count and kill count; a redirect kills everything still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_kill        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect_valid) begin
        r_req_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_kill   <= w_outstanding_next;
      end else begin
        if (w_accept) begin
          r_req_pc <= r_req_pc + XLEN'(INST_BYTES);
        end
        if (imem_resp_valid && (r_kill != '0)) begin
          r_kill <= r_kill - OW'(1);
        end
      end
    end
  end

  // Prefetch queue of {pc, inst} entries feeding decode.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_pfq (
    .clk   (clk),
    .reset (reset),
    .push  (w_deliver),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ({w_tag_pc, imem_resp_data}),
    .rdata (w_q_rdata),
    .count (w_q_count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  // PC tags of accepted requests; popped by every response, killed or not.
  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_tagq (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .wdata (r_req_pc),
    .rdata (w_tag_pc),
    .count (w_tag_count),
    .full  (w_tag_full),
    .empty (w_tag_empty)
  );

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch front end. It issues sequential PC requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses. Returned instructions are buffered in a small prefetch queue that feeds decode (ID). Supports decode backpressure and branch/jump redirect, and discards stale in-flight responses after a redirect.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h4000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered memory requests (>=1)
NOP_INST, 32'h0000_0013, instruction presented to ID when the queue is empty

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  redirect request from EX (branch/jump taken)
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
id_ready  in  1  ID can accept an instruction this cycle (low = stall)
id_valid  out  1  queue head valid
id_pc  out  XLEN  PC of queue head (0 when !id_valid)
id_inst  out  XLEN  instruction of queue head (NOP_INST when !id_valid)
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (word-aligned)
imem_resp_valid  in  1  response valid (in order, >=1 cycle after accept, no backpressure)
imem_resp_data  in  XLEN  response instruction

Behaviour:
- Reset: req_pc=RESET_PC; outstanding=0; kill=0; queue empty; id_valid=0; id_pc=0; id_inst=NOP_INST; imem_req_valid=0. Reset overrides every other input.
- Request issue: imem_req_valid=1 iff !redirect_valid && outstanding<MAX_OUTSTANDING && (outstanding+queue_count)<FIFO_DEPTH. imem_req_addr=req_pc, which is registered. On accept (valid&&ready): req_pc+=4 (wraps mod 2^XLEN), outstanding++, and the request's PC is pushed into an in-flight PC tag queue (depth MAX_OUTSTANDING).
- Credit rule guarantees every response has a queue slot. Queue overflow is impossible; an assertion checks it.
- Response: on imem_resp_valid: outstanding--, pop PC tag. If kill>0: kill--, discard. Otherwise push {tag_pc, data} into the queue.
- A response is visible on id_* the cycle after its arrival (no bypass). Minimum accept->id_valid latency = mem latency + 1.
- Dequeue: id_valid && id_ready pops the head. Push and pop in the same cycle are legal at any occupancy.
- Redirect (cycle t): queue flushed at end of t. kill <= outstanding after t's response, i.e. all requests accepted before t are dropped. req_pc <= {redirect_pc[XLEN-1:2],2'b00}. imem_req_valid is forced 0 in t. The first request for the target is issued at t+1. id_valid=0 at t+1.
- A redirect in the same cycle as a response: that response is decremented from outstanding and discarded. It is not counted into kill twice.
- Back-to-back redirects: the later one wins. kill accumulates correctly because no requests are accepted during a redirect cycle.
- id_ready=0 holds id_* stable. Prefetch continues until credits are exhausted.
- Counter widths: $clog2(MAX_OUTSTANDING+1) for outstanding and kill; $clog2(FIFO_DEPTH+1) for count.

Decomposition:
- fetch_pkg: XLEN, NOP_INST, INST_BYTES=4, and the typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO with parameter DEPTH and WIDTH, ports push/pop/flush/count/full/empty, flush-synchronous. It is instantiated twice: prefetch queue (width 2*XLEN) and PC tag queue (width XLEN).

Test Plan:
- Reset, then 1-cycle memory with ready always high and id_ready=1 -> requests 0x4000_0000, 0x4000_0004, ... consecutive. First id_valid at cycle 3 after reset deassert with id_pc=0x4000_0000. Afterwards one instruction per cycle.
- id_ready=0 for 10 cycles with a 1-cycle memory -> queue fills to 4, no further requests. id_pc is held. On release, 4 in-order instructions are seen with no loss or duplication.
- Memory latency 3 cycles, MAX_OUTSTANDING=2, redirect to 0x4000_0102 while 2 requests are in flight -> both responses dropped, next request addr 0x4000_0100, first id_pc after redirect is 0x4000_0100.
- Redirect in the same cycle as a response -> that response is never presented. kill returns to 0 and outstanding returns to 0 when idle.
- imem_req_ready randomly toggled (50%) with 1-3 cycle latency, 1000 instructions -> id_pc stream strictly sequential modulo redirects, id_inst matches the memory model.
- req_pc=0xFFFF_FFFC -> next request wraps to 0x0000_0000.
